// File: rtl/hdmi_i2c_config.sv
// Writes a {reg_addr,data} table to the HDMI transmitter over I2C once the config PLL locks.
// Bit-banged master: four quarter phases per SCL bit, SDA moves only while SCL is low.
module hdmi_i2c_config #(
    parameter int unsigned CLK_FREQ_HZ = 10_000_000,
    parameter int unsigned I2C_FREQ_HZ = 100_000,
    parameter logic [6:0]  DEV_ADDR    = 7'h59,
    parameter int unsigned REG_AW      = 16,
    parameter int unsigned TBL_DEPTH   = 64,
    parameter int unsigned PWR_DLY_CYC = 100_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              pll_lock,
    output logic [7:0]        tbl_idx,
    input  logic [REG_AW+7:0] tbl_data,
    output logic              scl,
    output logic              sda_o,
    output logic              sda_oe,
    input  logic              sda_i,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int unsigned QDIV   = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    localparam int unsigned QW     = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int unsigned DW     = (PWR_DLY_CYC > 1) ? $clog2(PWR_DLY_CYC + 1) : 1;
    localparam int unsigned RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned SW     = REG_AW + 16;
    localparam int unsigned NBYTES = REG_AW / 8 + 2;

    localparam logic [QW-1:0] QMAX      = QW'(QDIV - 1);
    localparam logic [DW-1:0] DMAX      = DW'(PWR_DLY_CYC - 1);
    localparam logic [RW-1:0] RMAX      = RW'(MAX_RETRY);
    localparam logic [7:0]    LAST_IDX  = 8'(TBL_DEPTH - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(NBYTES - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_PWR_DLY = 4'd1;
    localparam logic [3:0] S_START   = 4'd2;
    localparam logic [3:0] S_SEND    = 4'd3;
    localparam logic [3:0] S_ACK     = 4'd4;
    localparam logic [3:0] S_STOP    = 4'd5;
    localparam logic [3:0] S_NEXT    = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERR     = 4'd8;

    logic [3:0]    state;
    logic          lock_m;
    logic          lock_s;
    logic [QW-1:0] qcnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [DW-1:0] dly_cnt;
    logic [RW-1:0] retry_cnt;
    logic [SW-1:0] shreg;
    logic          nack;
    logic          tick;
    logic          bit_end;
    logic          running;
    logic          bit_state;

    assign tick      = (qcnt == QMAX);
    assign bit_end   = tick && (phase == 2'd3);
    assign running   = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
    assign bit_state = (state == S_START) || (state == S_SEND) || (state == S_ACK) ||
                       (state == S_STOP) || (state == S_NEXT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            qcnt      <= '0;
            phase     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            dly_cnt   <= '0;
            retry_cnt <= '0;
            shreg     <= '0;
            nack      <= 1'b0;
            tbl_idx   <= '0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
            if (running && !lock_s) begin
                // Lost lock: drop the bus and start over from entry 0 once lock returns.
                state     <= S_IDLE;
                qcnt      <= '0;
                phase     <= '0;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                dly_cnt   <= '0;
                retry_cnt <= '0;
                nack      <= 1'b0;
                tbl_idx   <= '0;
            end else begin
                if (bit_state) begin
                    qcnt <= tick ? '0 : qcnt + 1'b1;
                    if (tick) phase <= phase + 2'd1;
                end else begin
                    qcnt  <= '0;
                    phase <= '0;
                end
                case (state)
                    S_IDLE: begin
                        if (lock_s) begin
                            state   <= S_PWR_DLY;
                            dly_cnt <= '0;
                        end
                    end
                    S_PWR_DLY: begin
                        if (dly_cnt == DMAX) state <= S_START;
                        else dly_cnt <= dly_cnt + 1'b1;
                    end
                    S_START: begin
                        if (bit_end) begin
                            state    <= S_SEND;
                            shreg    <= {DEV_ADDR, 1'b0, tbl_data};
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            nack     <= 1'b0;
                        end
                    end
                    S_SEND: begin
                        if (bit_end) begin
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        // Sample at the centre of the SCL high phase.
                        if (tick && (phase == 2'd1)) nack <= sda_i;
                        if (bit_end) begin
                            if (nack || (byte_cnt == LAST_BYTE)) begin
                                state <= S_STOP;
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                                state    <= S_SEND;
                            end
                        end
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            if (!nack) begin
                                retry_cnt <= '0;
                                state     <= (tbl_idx == LAST_IDX) ? S_DONE : S_NEXT;
                            end else if (retry_cnt == RMAX) begin
                                state <= S_ERR;
                            end else begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= S_NEXT;
                            end
                        end
                    end
                    S_NEXT: begin
                        if (bit_end) begin
                            if (!nack) tbl_idx <= tbl_idx + 8'd1;
                            state <= S_START;
                        end
                    end
                    S_DONE, S_ERR: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        case (state)
            S_START: begin
                scl    = (phase != 2'd3);
                sda_oe = (phase != 2'd0);
            end
            S_SEND: begin
                scl    = (phase == 2'd1) || (phase == 2'd2);
                sda_oe = ~shreg[SW-1];
            end
            S_ACK: begin
                scl    = (phase == 2'd1) || (phase == 2'd2);
                sda_oe = 1'b0;
            end
            S_STOP: begin
                scl    = (phase != 2'd0);
                sda_oe = ~phase[1];
            end
            default: ;
        endcase
    end

    assign sda_o    = 1'b0;
    assign cfg_busy = running;
    assign cfg_done = (state == S_DONE);
    assign cfg_err  = (state == S_ERR);

endmodule

// File: tb/tb_hdmi_i2c_config.sv
// Bench for hdmi_i2c_config: I2C slave monitor with a byte scoreboard and directed scenarios.
module tb_hdmi_i2c_config;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pll_lock;
    logic [7:0]  tbl_idx;
    logic [23:0] tbl_data;
    logic        scl;
    logic        sda_o;
    logic        sda_oe;
    logic        sda_i;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic        slave_pull;

    int total = 0;
    int bad = 0;
    int n_start = 0;
    int n_bytes = 0;
    int nack_mode = 0;
    int nack_left = 0;
    int cyc = 0;
    bit allow_abort = 1'b0;
    bit check_period = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign sda_i = ~sda_oe & ~slave_pull;

    hdmi_i2c_config #(
        .CLK_FREQ_HZ(10_000_000),
        .I2C_FREQ_HZ(100_000),
        .DEV_ADDR   (7'h59),
        .REG_AW     (16),
        .TBL_DEPTH  (2),
        .PWR_DLY_CYC(100),
        .MAX_RETRY  (3)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .pll_lock(pll_lock),
        .tbl_idx (tbl_idx),
        .tbl_data(tbl_data),
        .scl     (scl),
        .sda_o   (sda_o),
        .sda_oe  (sda_oe),
        .sda_i   (sda_i),
        .cfg_busy(cfg_busy),
        .cfg_done(cfg_done),
        .cfg_err (cfg_err)
    );

    function automatic logic [23:0] tbl_val(input logic [7:0] i);
        case (i)
            8'd0:    tbl_val = 24'h1234A5;
            8'd1:    tbl_val = 24'hBEEF3C;
            default: tbl_val = {i, 8'h00, ~i};
        endcase
    endfunction

    always @(posedge clk) tbl_data <= tbl_val(tbl_idx);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [7:0] i);
        logic [23:0] v;
        v = tbl_val(i);
        exp_q.push_back(8'hB2);
        exp_q.push_back(v[23:16]);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(cfg_done || cfg_err) && (n < budget)) begin
            step(1);
            n++;
        end
        if (n >= budget) check("timeout_end", 32'(cfg_done | cfg_err), 32'd1);
    endtask

    task automatic wait_bytes(input int want, input int budget);
        int n;
        n = 0;
        while ((n_bytes < want) && (n < budget)) begin
            step(1);
            n++;
        end
        if (n >= budget) check("timeout_bytes", 32'(n_bytes), 32'(want));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step(5);
        exp_q.delete();
        allow_abort = 1'b0;
    endtask

    // Bus monitor and slave: decodes START/STOP/bytes, ACKs per nack_mode.
    initial begin
        logic       prev_scl;
        logic       prev_sda;
        logic       cur_sda;
        logic       ack_now;
        logic [7:0] shv;
        logic [7:0] expb;
        int         bitn;
        int         byte_in_txn;
        int         last_rise;
        prev_scl = 1'b1;
        prev_sda = 1'b1;
        ack_now = 1'b1;
        shv = '0;
        bitn = 0;
        byte_in_txn = 0;
        last_rise = 0;
        slave_pull = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            cur_sda = sda_i;
            if (!rstn) begin
                bitn = 0;
                byte_in_txn = 0;
                slave_pull = 1'b0;
                n_start = 0;
                n_bytes = 0;
                cur_sda = 1'b1;
            end else if (prev_scl && scl && (prev_sda != cur_sda)) begin
                if (!allow_abort) begin
                    if (!cur_sda) check("start_at_bit_boundary", 32'(bitn), 32'd0);
                    else check("stop_at_bit_boundary", 32'(bitn), 32'd1);
                end
                if (!cur_sda) begin
                    n_start++;
                    byte_in_txn = 0;
                end
                bitn = 0;
                slave_pull = 1'b0;
            end else if (!prev_scl && scl) begin
                if (check_period && (bitn >= 1) && (bitn <= 7))
                    check("scl_period", 32'(cyc - last_rise), 32'd100);
                last_rise = cyc;
                if (bitn < 8) begin
                    shv = {shv[6:0], cur_sda};
                    bitn++;
                    if (bitn == 8) begin
                        n_bytes++;
                        if (exp_q.size() == 0) begin
                            check("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
                        end else begin
                            expb = exp_q.pop_front();
                            check("sb_byte", 32'(shv), 32'(expb));
                        end
                        ack_now = 1'b1;
                        if (nack_mode == 2) ack_now = 1'b0;
                        else if ((nack_mode == 1) && (byte_in_txn == 3) && (nack_left > 0)) begin
                            ack_now = 1'b0;
                            nack_left--;
                        end
                    end
                end else begin
                    bitn = 9;
                end
            end else if (prev_scl && !scl) begin
                if (bitn == 8) slave_pull = ack_now;
                else if (bitn == 9) begin
                    slave_pull = 1'b0;
                    bitn = 0;
                    byte_in_txn++;
                end
            end
            prev_scl = (rstn === 1'b1) ? scl : 1'b1;
            prev_sda = cur_sda;
        end
    end

    // Directed sequence.
    initial begin
        rstn = 1'b0;
        pll_lock = 1'b1;

        // Reset values.
        step(5);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_sda_o", 32'(sda_o), 32'd0);
        check("rst_busy", 32'(cfg_busy), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_idx", 32'(tbl_idx), 32'd0);

        // Clean two-entry run.
        push_entry(8'd0);
        push_entry(8'd1);
        check_period = 1'b1;
        rstn = 1'b1;
        step(10);
        check("t2_busy_early", 32'(cfg_busy), 32'd1);
        wait_end(30000);
        check_period = 1'b0;
        check("t2_done", 32'(cfg_done), 32'd1);
        check("t2_err", 32'(cfg_err), 32'd0);
        check("t2_busy", 32'(cfg_busy), 32'd0);
        check("t2_idx", 32'(tbl_idx), 32'd1);
        check("t2_scl", 32'(scl), 32'd1);
        check("t2_sda_oe", 32'(sda_oe), 32'd0);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t2_starts", 32'(n_start), 32'd2);

        // Two NACKs on entry 0 data byte, then recovery.
        do_reset();
        nack_mode = 1;
        nack_left = 2;
        push_entry(8'd0);
        push_entry(8'd0);
        push_entry(8'd0);
        push_entry(8'd1);
        rstn = 1'b1;
        wait_end(30000);
        check("t3_done", 32'(cfg_done), 32'd1);
        check("t3_err", 32'(cfg_err), 32'd0);
        check("t3_starts", 32'(n_start), 32'd4);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Permanent NACK: retry exhaustion.
        do_reset();
        nack_mode = 2;
        repeat (4) exp_q.push_back(8'hB2);
        rstn = 1'b1;
        wait_end(30000);
        check("t4_err", 32'(cfg_err), 32'd1);
        check("t4_done", 32'(cfg_done), 32'd0);
        check("t4_busy", 32'(cfg_busy), 32'd0);
        check("t4_scl", 32'(scl), 32'd1);
        check("t4_sda_oe", 32'(sda_oe), 32'd0);
        check("t4_starts", 32'(n_start), 32'd4);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        step(500);
        check("t4_starts_after", 32'(n_start), 32'd4);
        check("t4_err_sticky", 32'(cfg_err), 32'd1);

        // Lock drop in the middle of entry 1, then relock.
        do_reset();
        nack_mode = 0;
        push_entry(8'd0);
        exp_q.push_back(8'hB2);
        rstn = 1'b1;
        wait_bytes(5, 20000);
        step(300);
        check("t5_busy_before", 32'(cfg_busy), 32'd1);
        pll_lock = 1'b0;
        allow_abort = 1'b1;
        step(3);
        check("t5_scl", 32'(scl), 32'd1);
        check("t5_sda_oe", 32'(sda_oe), 32'd0);
        check("t5_busy", 32'(cfg_busy), 32'd0);
        check("t5_idx", 32'(tbl_idx), 32'd0);
        step(20);
        check("t5_idle_hold", 32'(cfg_busy), 32'd0);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        push_entry(8'd0);
        push_entry(8'd1);
        pll_lock = 1'b1;
        wait_end(30000);
        check("t5_done", 32'(cfg_done), 32'd1);
        check("t5_err", 32'(cfg_err), 32'd0);
        check("t5_final_idx", 32'(tbl_idx), 32'd1);
        check("t5_sb_empty_end", 32'(exp_q.size()), 32'd0);

        // Reset asserted mid-byte.
        do_reset();
        push_entry(8'd0);
        rstn = 1'b1;
        wait_bytes(1, 5000);
        step(200);
        check("t6_busy_before", 32'(cfg_busy), 32'd1);
        allow_abort = 1'b1;
        rstn = 1'b0;
        step(1);
        check("t6_scl", 32'(scl), 32'd1);
        check("t6_sda_oe", 32'(sda_oe), 32'd0);
        check("t6_busy", 32'(cfg_busy), 32'd0);
        check("t6_done", 32'(cfg_done), 32'd0);
        check("t6_err", 32'(cfg_err), 32'd0);
        check("t6_idx", 32'(tbl_idx), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
